// File: rtl/serial_pkg.sv
// Shared types for the serializer and the bit-stream sequence detectors.
package serial_pkg;

    localparam int unsigned SER_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_t;

endpackage

// File: rtl/bit_counter.sv
// Clearable up-counter over one word's data bits; tc_c flags the last bit (WIDTH-1).
module bit_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [CW-1:0] count;

    assign tc_c = (count == CW'(WIDTH - 1));

    // Wraps at terminal count so a non-power-of-two WIDTH never runs past WIDTH-1.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc_c ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end feeding the sequence detectors a gap-free bit stream.
// Optional trailing even-parity bit per word when BIT_SERIALIZER_PARITY_EN is defined.
module bit_serializer
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH     = SER_WIDTH_DEFAULT,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy
);

    ser_state_t       state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] next_sreg_c;
    logic             head_c;
    logic             last_c;
    logic             accept_c;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic             par;
`endif

    assign head_c      = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
    assign next_sreg_c = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};

    // Ready on the final emitted bit of a word so the next word follows without a gap.
`ifdef BIT_SERIALIZER_PARITY_EN
    assign din_ready = !rst && (state == IDLE || state == PARITY);
`else
    assign din_ready = !rst && (state == IDLE || (state == SHIFT && last_c));
`endif

    assign accept_c = din_valid && din_ready;

    bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept_c),
        .en    (state == SHIFT),
        .tc_c  (last_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sreg       <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            busy       <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        state <= SHIFT;
                        sreg  <= din;
                        busy  <= 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
                        par   <= ^din;
`endif
                    end
                end
                SHIFT: begin
                    sout       <= head_c;
                    sout_valid <= 1'b1;
                    sreg       <= next_sreg_c;
                    if (last_c) begin
`ifdef BIT_SERIALIZER_PARITY_EN
                        state <= PARITY;
`else
                        if (accept_c) begin
                            sreg <= din;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
`endif
                    end
                end
`ifdef BIT_SERIALIZER_PARITY_EN
                PARITY: begin
                    sout       <= par;
                    sout_valid <= 1'b1;
                    if (accept_c) begin
                        state <= SHIFT;
                        sreg  <= din;
                        par   <= ^din;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the bit-stream sequence detectors. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on `sout`, which drives the detector's serial `in` input directly. Consecutive words are emitted with no idle cycle between them, so the downstream FSM sees one continuous bit stream and can detect patterns that span word boundaries.

## Interface
- `WIDTH`, 8, data word width in bits; legal range is WIDTH ≥ 2.
- `MSB_FIRST`, 1, bit order: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `din`  in  WIDTH  parallel word; sampled only on the accept cycle.
- `din_valid`  in  1  producer has a word on `din`.
- `din_ready`  out  1  serializer can accept a word this cycle.
- `sout`  out  1  serial bit to the detector; registered.
- `sout_valid`  out  1  `sout` carries a real bit this cycle; registered.
- `busy`  out  1  a word is currently being shifted out (state ≠ IDLE).

## Operation
- A word is accepted on a clock edge where `din_valid && din_ready` is true.
- Once the producer raises `din_valid`, it holds `din_valid` high and `din` stable until the word is accepted.
- States:
  - IDLE: no word in flight.
  - SHIFT: data bits are being sent.
  - PARITY: parity bit is being sent; exists only when the macro is defined.
- IDLE → SHIFT on accept.
  - The shift register loads `din`.
  - The bit counter is cleared to 0.
- In SHIFT, every cycle:
  - `sout` = current head bit (MSB or LSB, per `MSB_FIRST`).
  - `sout_valid` = 1.
  - The shift register shifts by one and the counter increments.
- The counter is $clog2(WIDTH) bits wide. The last data bit is the cycle with count == WIDTH-1.
- `din_ready` is combinational and is 1 when either condition holds (and is always 0 while `rst` is high):
  - state == IDLE; or
  - the last-bit cycle of the word (the last SHIFT cycle without the macro, the PARITY cycle with it).
- At the last-bit cycle:
  - Accept in the same cycle → reload and stay in (or re-enter) SHIFT. There is no gap bit.
  - No accept → go to IDLE. `sout`=0 and `sout_valid`=0 from the next cycle on.
- `din_valid` arriving while `din_ready`=0 has no effect; the word waits.
- Reset while `rst`=1 at any point, including mid-word:
  - State → IDLE on the next edge.
  - The partial word is discarded.
  - `sout`=0, `sout_valid`=0, `busy`=0.

## Timing
- Reset values: `sout`=0, `sout_valid`=0, `busy`=0, `din_ready`=0 while `rst` is high, then `din_ready`=1 in the first cycle after `rst` falls.
- Latency: a word accepted at edge N puts its first bit on `sout` after edge N+1. The last data bit appears after edge N+WIDTH.
- Throughput with a continuously valid producer:
  - Without the macro: one word per WIDTH cycles, 100% bit utilisation.
  - With the macro: one word per WIDTH+1 cycles.
- The detector samples `sout` on the same `clk`. `sout_valid` is informational only; the detector ignores it and sees 0 during idle.

## Configuration
- Macro: `BIT_SERIALIZER_PARITY_EN`.
- Defined:
  - After the last data bit, one PARITY cycle emits even parity (XOR of all WIDTH bits of the word) with `sout_valid`=1.
  - `din_ready` asserts in the PARITY cycle instead of the last SHIFT cycle.
- Undefined: the PARITY state and parity register are not present. SHIFT returns directly to IDLE or reloads.

## Structure
- Package `serial_pkg`:
  - `ser_state_t` enum {IDLE, SHIFT, PARITY} as logic [1:0].
  - Default WIDTH constant.
- The detector shares the package for future enums.
- One sub-module is natural: `bit_counter`, a clearable up-counter with a terminal-count output at WIDTH-1.
- The shift register and FSM stay in `bit_serializer`.

## Test plan
- Reset: `rst`=1 for 2 cycles with `din_valid`=1, `din`=8'hFF → `sout`=0, `sout_valid`=0, `din_ready`=0 throughout; `din_ready`=1 in the first cycle after release; no word accepted during reset.
- Single word: MSB_FIRST=1, accept 8'hA5 at edge N → `sout` = 1,0,1,0,0,1,0,1 on cycles N+1..N+8 with `sout_valid`=1; cycle N+9: `sout`=0, `sout_valid`=0, `busy`=0.
- Back-to-back: 8'h05 then 8'h40 held valid → 16 contiguous valid bits ...0,1,0,1,0,1,0...; `din_ready`=1 only in cycle N+8; the downstream 101 detector pulses twice, including the match across the word boundary.
- LSB first: MSB_FIRST=0, 8'h01 → `sout` = 1 followed by seven 0s.
- Reset mid-word: 8'hFF, `rst` high after 3 bits → next cycle `sout_valid`=0; the next word 8'h80 starts fresh with first bit 1 then 0s.
- Parity (macro defined): 8'h07 → 9th bit 1 and next accept at the 9th cycle; 8'h03 → 9th bit 0. Macro undefined: 9th cycle idle (`sout_valid`=0).
